// File: rtl/dmem_controller_pkg.sv
// Bundle: shared types for the data-memory controller.
//   mem_fcn_e / mem_typ_e : memory function and access width/sign encodings
//   MemoryIn / MemoryOut  : memory-stage request and response bundles
//   state_e               : controller FSM states
//   helpers               : misalignment test, write strobes, lane replication,
//                           load sign-extension select
package Bundle;

  typedef enum logic [1:0] {M_X = 2'd0, M_XRD = 2'd1, M_XWR = 2'd2} mem_fcn_e;

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_BU = 3'd5,
    MT_HU = 3'd6
  } mem_typ_e;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  typedef struct packed {
    logic [31:0] addr;
    mem_fcn_e    fcn;
    mem_typ_e    typ;
    logic [31:0] data;
  } mem_req_t;

  typedef struct packed {
    logic     req_valid;
    mem_req_t req;
  } MemoryIn;

  typedef struct packed {
    logic [31:0] data;
  } mem_res_t;

  typedef struct packed {
    logic     res_valid;
    mem_res_t res;
  } MemoryOut;

  function automatic logic is_byte(mem_typ_e t);
    return (t == MT_B) || (t == MT_BU);
  endfunction

  function automatic logic is_half(mem_typ_e t);
    return (t == MT_H) || (t == MT_HU);
  endfunction

  // Signed variants sign-extend on load; unsigned ones zero-extend.
  function automatic logic sign_ext(mem_typ_e t);
    return (t == MT_B) || (t == MT_H);
  endfunction

  // Anything that is not a byte or halfword is treated as a word access.
  function automatic logic misaligned(mem_typ_e t, logic [1:0] off);
    if (is_byte(t)) return 1'b0;
    if (is_half(t)) return off[0];
    return off != 2'b00;
  endfunction

  function automatic logic [3:0] wstrb_of(mem_typ_e t, logic [1:0] off);
    if (is_byte(t)) return 4'b0001 << off;
    if (is_half(t)) return 4'b0011 << off;
    return 4'b1111;
  endfunction

  // Store data is replicated so the addressed lane carries it whatever the offset.
  function automatic logic [31:0] wdata_of(mem_typ_e t, logic [31:0] d);
    if (is_byte(t)) return {4{d[7:0]}};
    if (is_half(t)) return {2{d[15:0]}};
    return d;
  endfunction

endpackage

// File: rtl/dmem_controller_load_formatter.sv
// load_formatter: selects the addressed byte/halfword from a bus word and
// sign- or zero-extends it. Purely combinational.
//   typ   : access type of the load
//   off   : address bits [1:0]
//   rdata : raw 32-bit bus read data
//   data  : formatted load result
module load_formatter
  import Bundle::*;
(
  input  mem_typ_e    typ,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    if (is_byte(typ))      data = {{24{sign_ext(typ) & b[7]}}, b};
    else if (is_half(typ)) data = {{16{sign_ext(typ) & h[15]}}, h};
  end

endmodule

// File: rtl/dmem_controller.sv
// dmem_controller: bridges the memory stage to a request/response bus, one
// access outstanding at a time.
//   clk, rst_n           : clock, async active-low reset
//   dmem_in / dmem_out   : memory-stage request / response bundles
//   cmiss_stall          : pipeline freeze while an access is in flight
//   fault                : one-cycle pulse with the response on misalign/bus error/timeout
//   bus_req_valid/ready  : bus request handshake
//   bus_addr, bus_we, bus_wstrb, bus_wdata : word address, write controls, lane data
//   bus_rsp_valid, bus_rdata, bus_err      : bus response
module dmem_controller
  import Bundle::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  MemoryIn     dmem_in,
  output MemoryOut    dmem_out,
  output logic        cmiss_stall,
  output logic        fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      state;
  mem_typ_e    typ_q;
  logic [1:0]  off_q;
  logic [CW-1:0] tmo_cnt;
  logic [31:0] fmt_data;
  logic        new_req;
  logic        bad_align;
  logic        is_wr;

  assign new_req   = dmem_in.req_valid &&
                     (dmem_in.req.fcn == M_XRD || dmem_in.req.fcn == M_XWR);
  assign bad_align = misaligned(dmem_in.req.typ, dmem_in.req.addr[1:0]);
  assign is_wr     = dmem_in.req.fcn == M_XWR;

  // The idle term is combinational so the pipeline freezes in the accept cycle;
  // rst_n gates it so all outputs read 0 while reset is held.
  assign cmiss_stall = (state == REQ) || (state == WAIT) ||
                       (state == IDLE && new_req && rst_n);

  load_formatter u_fmt (
    .typ  (typ_q),
    .off  (off_q),
    .rdata(bus_rdata),
    .data (fmt_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      typ_q         <= MT_X;
      off_q         <= 2'b00;
      tmo_cnt       <= '0;
      dmem_out      <= '0;
      fault         <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_addr      <= '0;
      bus_we        <= 1'b0;
      bus_wstrb     <= '0;
      bus_wdata     <= '0;
    end else begin
      dmem_out.res_valid <= 1'b0;
      fault              <= 1'b0;
      case (state)
        IDLE: if (new_req) begin
          typ_q <= dmem_in.req.typ;
          off_q <= dmem_in.req.addr[1:0];
          if (bad_align) begin
            state              <= DONE;
            dmem_out.res_valid <= 1'b1;
            dmem_out.res.data  <= '0;
            fault              <= 1'b1;
          end else begin
            state         <= REQ;
            bus_req_valid <= 1'b1;
            bus_addr      <= {dmem_in.req.addr[31:2], 2'b00};
            bus_we        <= is_wr;
            bus_wstrb     <= is_wr ? wstrb_of(dmem_in.req.typ, dmem_in.req.addr[1:0]) : 4'b0000;
            bus_wdata     <= wdata_of(dmem_in.req.typ, dmem_in.req.data);
          end
        end
        // Responses seen here belong to nothing of ours and are ignored.
        REQ: if (bus_req_ready) begin
          bus_req_valid <= 1'b0;
          tmo_cnt       <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          if (bus_rsp_valid) begin
            state              <= DONE;
            dmem_out.res_valid <= 1'b1;
            dmem_out.res.data  <= bus_we ? 32'd0 : fmt_data;
            fault              <= bus_err;
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            state              <= DONE;
            dmem_out.res_valid <= 1'b1;
            dmem_out.res.data  <= '0;
            fault              <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        // The pipeline advances out of DONE, so no re-issue of the same request.
        DONE: begin
          state             <= IDLE;
          dmem_out.res.data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
module tb_dmem_controller;
  import Bundle::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  MemoryIn     dmem_in;
  MemoryOut    dmem_out;
  logic        cmiss_stall, fault;
  logic        bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  dmem_controller #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .dmem_in(dmem_in), .dmem_out(dmem_out),
    .cmiss_stall(cmiss_stall), .fault(fault),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic        flt;
  } exp_t;
  exp_t exp_q[$];

  // Plan for the bus responder, set by the driver before each request.
  logic        plan_bus = 1'b0;
  logic [31:0] plan_addr = '0, plan_wdata = '0, plan_rdata = '0;
  logic        plan_we = 1'b0, plan_err = 1'b0, plan_junk = 1'b0;
  logic [3:0]  plan_wstrb = '0;
  int          plan_rd = 0, plan_rsp = 0;
  logic        resp_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_mis(mem_typ_e t, logic [31:0] a);
    if (t == MT_W) return (a % 4) != 0;
    if (t == MT_H || t == MT_HU) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(mem_typ_e t, logic [31:0] a, logic [31:0] rd);
    int unsigned v;
    v = rd;
    if (t == MT_B || t == MT_BU) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (t == MT_B && v >= 128) v = v - 256;
    end else if (t == MT_H || t == MT_HU) begin
      v = (rd >> (8 * (a % 4))) & 32'hFFFF;
      if (t == MT_H && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] strb_val(mem_typ_e t, logic [31:0] a);
    if (t == MT_B) return 4'(1 << (a % 4));
    if (t == MT_H) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdat_val(mem_typ_e t, logic [31:0] d);
    if (t == MT_B) return (d & 32'hFF) * 32'h0101_0101;
    if (t == MT_H) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input logic [31:0] a, input mem_fcn_e f, input mem_typ_e t,
                         input logic [31:0] d, input int rdl, input int rsp,
                         input logic [31:0] rdat, input logic e, input logic junk);
    exp_t x;
    int   exp_stall, st;
    logic mis, wr;
    mis = is_mis(t, a);
    wr  = (f == M_XWR);
    plan_bus = !mis; plan_addr = a & ~32'h3; plan_we = wr;
    plan_wstrb = strb_val(t, a); plan_wdata = wdat_val(t, d);
    plan_rd = rdl; plan_rsp = rsp; plan_rdata = rdat; plan_err = e; plan_junk = junk;
    if (mis) begin
      x.data = 0; x.flt = 1; exp_stall = 1;
    end else if (rsp >= TMO) begin
      x.data = 0; x.flt = 1; exp_stall = 2 + rdl + TMO;
    end else begin
      x.data = wr ? 32'd0 : load_val(t, a, rdat); x.flt = e; exp_stall = 3 + rdl + rsp;
    end
    exp_q.push_back(x);
    @(posedge clk); #1;
    dmem_in.req_valid = 1'b1;
    dmem_in.req.addr = a; dmem_in.req.fcn = f; dmem_in.req.typ = t; dmem_in.req.data = d;
    st = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!cmiss_stall) break;
      st++;
    end
    dmem_in.req_valid = 1'b0;
    check("stall_cycles", 64'(st), 64'(exp_stall));
    for (int i = 0; i < 50 && resp_busy; i++) @(negedge clk);
  endtask

  // ---------------- bus responder ----------------
  initial begin
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0; bus_err = 0;
    forever begin
      @(negedge clk);
      if (bus_req_valid === 1'b1) begin
        resp_busy = 1'b1;
        if (!plan_bus) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_bus_req: addr %0h, expected no bus request", bus_addr);
        end
        for (int i = 0; i <= plan_rd; i++) begin
          if (i > 0) @(negedge clk);
          check("bus_req_valid_held", 64'(bus_req_valid), 64'd1);
          check("bus_addr", 64'(bus_addr), 64'(plan_addr));
          check("bus_we", 64'(bus_we), 64'(plan_we));
          if (plan_we) check("bus_wstrb_wdata", {28'd0, bus_wstrb, bus_wdata}, {28'd0, plan_wstrb, plan_wdata});
        end
        bus_req_ready = 1'b1;
        if (plan_junk) begin bus_rsp_valid = 1'b1; bus_rdata = $urandom; bus_err = 1'b1; end
        @(negedge clk);
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_err = 1'b0;
        check("bus_req_dropped", 64'(bus_req_valid), 64'd0);
        for (int i = 0; i < plan_rsp; i++) @(negedge clk);
        bus_rsp_valid = 1'b1; bus_rdata = plan_rdata; bus_err = plan_err;
        @(negedge clk);
        bus_rsp_valid = 1'b0; bus_err = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (dmem_out.res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_response: data %0h fault %0b, expected none", dmem_out.res.data, fault);
        end else begin
          x = exp_q.pop_front();
          check("res_data", 64'(dmem_out.res.data), 64'(x.data));
          check("res_fault", 64'(fault), 64'(x.flt));
        end
      end else if (fault !== 1'b0) begin
        n_vec++; n_err++;
        $display("FAIL stray_fault: fault %0b without res_valid, expected 0", fault);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    mem_typ_e rtyps[5];
    mem_typ_e wtyps[3];
    mem_fcn_e f;
    mem_typ_e t;
    bit       seen;
    int       rsp;
    rtyps = '{MT_B, MT_H, MT_W, MT_BU, MT_HU};
    wtyps = '{MT_B, MT_H, MT_W};
    dmem_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    dmem_in.req_valid = 1'b1; dmem_in.req.fcn = M_XRD; dmem_in.req.typ = MT_W;
    #1;
    check("reset_ctrl_outputs",
          {23'd0, dmem_out.res_valid, cmiss_stall, fault, bus_req_valid, bus_we, bus_wstrb, dmem_out.res.data},
          64'd0);
    check("reset_bus_outputs", {bus_addr, bus_wdata}, 64'd0);
    dmem_in = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // LB 0x103, one-cycle latencies
    run_txn(32'h103, M_XRD, MT_B, 0, 0, 0, 32'h80FF_FF00, 0, 0);
    // SH 0x202
    run_txn(32'h202, M_XWR, MT_H, 32'h0000_BEEF, 0, 1, 0, 0, 0);
    // LW misaligned
    run_txn(32'h006, M_XRD, MT_W, 0, 0, 0, 0, 0, 0);
    // ready held low 5 cycles
    run_txn(32'h040, M_XRD, MT_W, 0, 5, 1, 32'h1234_5678, 0, 0);
    // no response: timeout, late response in IDLE discarded
    run_txn(32'h080, M_XRD, MT_W, 0, 0, TMO + 2, 32'hDEAD_BEEF, 0, 0);
    // response in the handshake cycle ignored; bus error reported
    run_txn(32'h002, M_XRD, MT_HU, 0, 1, 2, 32'hA5A5_5A5A, 1, 1);

    // M_X with req_valid is no request
    plan_bus = 1'b0;
    @(posedge clk); #1;
    dmem_in.req_valid = 1'b1; dmem_in.req.fcn = M_X; dmem_in.req.addr = 32'h10; dmem_in.req.typ = MT_W;
    @(negedge clk); check("mx_no_stall", 64'(cmiss_stall), 64'd0);
    @(posedge clk); #1; dmem_in.req_valid = 1'b0;
    @(negedge clk); check("mx_still_idle", 64'(cmiss_stall), 64'd0);

    // reset asserted during WAIT
    plan_bus = 1'b1; plan_addr = 32'h100; plan_we = 1'b0; plan_rd = 0; plan_rsp = TMO + 3;
    plan_rdata = 32'h5555_5555; plan_err = 1'b0; plan_junk = 1'b0;
    @(posedge clk); #1;
    dmem_in.req_valid = 1'b1; dmem_in.req.fcn = M_XRD; dmem_in.req.typ = MT_W; dmem_in.req.addr = 32'h100;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_req_valid) seen = 1;
      else if (seen) break;
    end
    #2; rst_n = 1'b0; #1;
    check("async_reset_mid_wait",
          {60'd0, cmiss_stall, dmem_out.res_valid, fault, bus_req_valid}, 64'd0);
    dmem_in.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50 && resp_busy; i++) @(negedge clk);
    run_txn(32'h001, M_XRD, MT_BU, 0, 0, 0, 32'h0000_9A00, 0, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      f = ($urandom_range(0, 1) == 1) ? M_XWR : M_XRD;
      t = (f == M_XWR) ? wtyps[$urandom_range(0, 2)] : rtyps[$urandom_range(0, 4)];
      rsp = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, TMO - 1);
      run_txn($urandom & 32'h0000_0FFF, f, t, $urandom, $urandom_range(0, 3), rsp,
              $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dmem_controller.md
DMEM_CONTROLLER -- requirements
Module: dmem_controller

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum cycles in WAIT before the transaction is aborted with a fault.
REQ-002 clk  input  1  single pipeline clock, rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 dmem_in  input  Bundle::MemoryIn  request from the memory stage: req_valid, req.addr[31:0], req.fcn, req.typ, req.data[31:0].
REQ-005 dmem_out  output  Bundle::MemoryOut  response to the memory stage: res_valid, res.data[31:0].
REQ-006 cmiss_stall  output  1  freezes the pipeline while an access is outstanding.
REQ-007 fault  output  1  one-cycle pulse on a misaligned access, bus error or timeout.
REQ-008 bus_req_valid / bus_req_ready  output / input  1 / 1  bus request handshake.
REQ-009 bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-010 bus_we, bus_wstrb, bus_wdata  output  1, 4, 32  write enable, byte strobes, lane-aligned write data.
REQ-011 bus_rsp_valid, bus_rdata, bus_err  input  1, 32, 1  bus response.

Function
REQ-012 FSM states SHALL be IDLE, REQ, WAIT, DONE; one outstanding access maximum.
REQ-013 IDLE: req_valid=1 and aligned -> latch request, go to REQ; cmiss_stall SHALL be asserted combinationally in this same cycle.
REQ-014 REQ: bus_req_valid=1 with stable address, we, wstrb and wdata until bus_req_ready=1; the handshake cycle moves to WAIT.
REQ-015 WAIT: bus_rsp_valid=1 -> capture bus_rdata and bus_err, go to DONE; a response in the handshake cycle itself SHALL be ignored.
REQ-016 DONE: cmiss_stall=0, res_valid=1, res.data = formatted load data; fault=1 if bus_err was captured; next state IDLE unconditionally, and the same request SHALL NOT be re-issued.
REQ-017 cmiss_stall SHALL be 1 in REQ and WAIT, and 0 in DONE and in IDLE when req_valid=0.
REQ-018 Misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=0): no bus transaction; go to DONE with fault=1 and res.data=0.
REQ-019 Write strobes: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111. Write data SHALL be replicated across lanes.
REQ-020 Load format: B/BU -> byte at addr[1:0], sign- or zero-extended; H/HU -> halfword at addr[1], sign- or zero-extended; W -> unchanged.
REQ-021 Writes SHALL still wait for bus_rsp_valid; res.data for a write is 0.
REQ-022 Timeout counter: cleared on entry to WAIT, increments each WAIT cycle; reaching TIMEOUT forces DONE with fault=1 and res.data=0.
REQ-023 A late bus_rsp_valid arriving in IDLE SHALL be discarded.
REQ-024 req.fcn other than read or write (M_X) with req_valid=1 SHALL be treated as no request.

Reset
REQ-025 rst_n low SHALL force state IDLE and clear latched request, captured data and timeout counter; all outputs 0.
REQ-026 Reset asserted mid-transaction SHALL abandon it with no response; the bus side is responsible for its own reset.

Structure
REQ-027 The FSM state enum and the mask-type-to-strobe/extension helper functions SHALL live in the Bundle package.
REQ-028 The load alignment/extension logic SHALL be one combinational sub-module, load_formatter.

Verification
REQ-029 LB at 0x103 with bus_rdata=0x80FF_FF00 and one-cycle ready/response latency -> wstrb n/a, res.data=0xFFFF_FF80, cmiss_stall high for exactly 3 cycles.
REQ-030 SH at 0x202, data 0x0000_BEEF -> bus_wstrb=4'b1100, bus_wdata=0xBEEF_BEEF, bus_we=1.
REQ-031 LW at 0x006 -> no bus_req_valid, fault pulse, res.data=0, stall for 1 cycle.
REQ-032 bus_req_ready held low for 5 cycles -> bus_req_valid and address stable throughout; completes normally afterwards.
REQ-033 TIMEOUT=4, no response -> DONE after 4 WAIT cycles with fault=1; a later bus_rsp_valid is ignored.
REQ-034 rst_n asserted during WAIT -> IDLE with cmiss_stall=0 immediately (asynchronous); next LBU at 0x001 with rdata 0x0000_9A00 -> 0x0000_009A.
